// File: rtl/fetch_mem_arbiter.sv
// Shares one single-port, fixed-latency RAM between instruction fetch and load/store.
// Data accesses win by default; a streak counter bounds how long fetch can be starved.
module fetch_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,

    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int unsigned   SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
    localparam logic [1:0]    LAT        = 2'(RAM_LAT);

    logic [0:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          flushed_q, flushed_d;
    logic [SW-1:0] streak_q, streak_d;

    logic fetch_eff;
    logic grant_d;
    logic grant_i;

    assign fetch_eff = i_req & ~i_flush;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        flushed_d = flushed_q;
        streak_d  = streak_q;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;

        // Nothing is granted or acknowledged while reset is asserted.
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    grant_d = d_req & ~(fetch_eff & (streak_q == STREAK_MAX));
                    grant_i = ~grant_d & fetch_eff;
                    if (grant_d) begin
                        ram_en    = 1'b1;
                        ram_we    = d_we;
                        ram_addr  = d_addr;
                        ram_wdata = d_wdata;
                        owner_d   = OWN_D;
                        streak_d  = fetch_eff ? streak_q + SW'(1) : '0;
                    end else if (grant_i) begin
                        ram_en    = 1'b1;
                        ram_addr  = i_addr;
                        owner_d   = OWN_I;
                        streak_d  = '0;
                    end
                    if (grant_d || grant_i) begin
                        state_d   = ST_BUSY;
                        cnt_d     = 2'd1;
                        flushed_d = 1'b0;
                    end
                end
                default: begin
                    if (i_flush && owner_q == OWN_I) begin
                        flushed_d = 1'b1;
                    end
                    if (cnt_q == LAT) begin
                        if (owner_q == OWN_I) begin
                            i_ack   = ~flushed_q;
                            i_rdata = flushed_q ? '0 : ram_rdata;
                        end else begin
                            d_ack   = 1'b1;
                            d_rdata = ram_rdata;
                        end
                        state_d = ST_IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            endcase
        end
    end

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            owner_q   <= OWN_I;
            flushed_q <= 1'b0;
            streak_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            flushed_q <= flushed_d;
            streak_q  <= streak_d;
        end
    end

endmodule
